// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO read-side stream adapter:
// burst-length legality and burst-counter sizing.
package async_fifo_pkg;

  typedef logic [1:0] occ_t;

  localparam int MAX_BURST = 256;

  function automatic bit burst_ok(input int burst);
    return (burst >= 1) && (burst <= MAX_BURST);
  endfunction

  // A BURST of 1 or 2 still needs one counter bit.
  function automatic int bcnt_width(input int burst);
    return (burst <= 2) ? 1 : $clog2(burst);
  endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry ordered register buffer: pop shifts tail into head, and a pushed
// word lands in the lowest slot that is free after that shift.
module stream_skid_buf2
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] data,
  input  logic             pop,
  output occ_t             occ,
  output logic [DSIZE-1:0] head
);

  logic [DSIZE-1:0] tail;
  logic [DSIZE-1:0] head_s;
  logic [DSIZE-1:0] head_n;
  logic [DSIZE-1:0] tail_n;
  occ_t             occ_s;
  occ_t             occ_n;

  always_comb begin
    occ_s  = occ;
    head_s = head;
    head_n = head;
    tail_n = tail;
    occ_n  = occ;
    if (pop && (occ != 2'd0)) begin
      head_s = tail;
      occ_s  = occ - 2'd1;
    end
    head_n = head_s;
    // The caller never pushes into a full buffer, so occ_s is 0 or 1 here.
    if (push) begin
      if (occ_s == 2'd0) head_n = data;
      else               tail_n = data;
    end
    occ_n = occ_s + (push ? 2'd1 : 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      occ  <= occ_n;
      head <= head_n;
      tail <= tail_n;
    end
  end

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Pops a first-word-fall-through FIFO into a 2-entry buffer and presents a
// valid/ready stream with a burst-boundary marker on every BURST-th beat.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int BURST = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             idle
);

  localparam int BW = bcnt_width(BURST);
  localparam logic [BW-1:0] LAST_CNT = BW'(BURST - 1);

  if (!burst_ok(BURST)) begin : g_bad_burst
    $error("async_fifo_rd_stream: BURST must be within 1..256");
  end

  occ_t          occ;
  logic          acc;
  logic [BW-1:0] bcnt;

  // Handshake: a beat transfers on the rclk edge where m_valid && m_ready;
  // m_valid never waits on m_ready, and m_valid/m_data/m_last hold until the
  // transfer. On the FIFO side, rinc looks only at en, rempty and occupancy,
  // so no combinational path runs from m_ready back to the FIFO.
  assign rinc    = en && !rempty && (occ < 2'd2);
  assign m_valid = (occ != 2'd0);
  assign idle    = (occ == 2'd0);
  assign acc     = m_valid && m_ready;
  assign m_last  = m_valid && (bcnt == LAST_CNT);

  stream_skid_buf2 #(
    .DSIZE(DSIZE)
  ) u_buf (
    .clk  (rclk),
    .rst_n(rrst_n),
    .push (rinc),
    .data (rdata),
    .pop  (acc),
    .occ  (occ),
    .head (m_data)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bcnt <= '0;
    end else if (acc) begin
      bcnt <= (bcnt == LAST_CNT) ? '0 : bcnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed bench for async_fifo_rd_stream: a queue stands in for the FIFO
// read port, and every expected beat and flag is written out by hand.
module tb_async_fifo_rd_stream;

  logic        clk;
  logic        rrst_n;
  logic        en;
  logic        rempty;
  logic [31:0] rdata;
  logic        m_ready;

  logic        rinc;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        idle;

  logic        rinc1;
  logic        m_valid1;
  logic [31:0] m_data1;
  logic        m_last1;
  logic        idle1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int cyc      = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_data_q[$];
  bit          obs_last_q[$];
  int          obs_cyc_q[$];

  async_fifo_rd_stream #(.DSIZE(32), .BURST(8)) dut (
    .rclk(clk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rinc(rinc),
    .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .idle(idle)
  );

  async_fifo_rd_stream #(.DSIZE(32), .BURST(1)) dut1 (
    .rclk(clk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rinc(rinc1),
    .rdata(rdata), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_last(m_last1), .idle(idle1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic refresh_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 32'd0 : fifo_q[0];
  endtask

  task automatic load_fifo(input int first, input int count);
    for (int i = 0; i < count; i++) fifo_q.push_back(32'(first + i));
    refresh_fifo();
  endtask

  task automatic clear_obs();
    obs_data_q.delete();
    obs_last_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
  endtask

  // Samples just before the edge, then models the FIFO pop just after it.
  task automatic cycle();
    bit pop;
    #1;
    pop = rinc;
    if (pop) n_pops++;
    if (m_valid && m_ready) begin
      obs_data_q.push_back(m_data);
      obs_last_q.push_back(m_last);
      obs_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_data_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    ok = (obs_data_q.size() >= n);
  endtask

  task automatic test_reset();
    rrst_n  = 1'b0;
    en      = 1'b1;
    m_ready = 1'b0;
    fifo_q.delete();
    refresh_fifo();
    #2;
    n_checks++;
    if (rinc !== 1'b0 || m_valid !== 1'b0 || idle !== 1'b1 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got rinc=%b valid=%b idle=%b last=%b expected 0 0 1 0",
               rinc, m_valid, idle, m_last);
    end
    n_checks++;
    if (m_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h expected 0", m_data);
    end
    #10;
    rrst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    n_checks++;
    if (rinc !== 1'b0 || m_valid !== 1'b0 || idle !== 1'b1 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_empty: got rinc=%b valid=%b idle=%b last=%b expected 0 0 1 0",
               rinc, m_valid, idle, m_last);
    end
  endtask

  task automatic test_stream();
    bit ok;
    clear_obs();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    load_fifo(0, 10);
    m_ready = 1'b1;
    run_until(10, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats expected 10", obs_data_q.size());
    end
    n_checks++;
    if (obs_cyc_q.size() == 10 && (obs_cyc_q[9] - obs_cyc_q[0]) != 9) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d cycles for 10 beats expected 9 between first and last",
               obs_cyc_q[9] - obs_cyc_q[0]);
    end
    // Six more beats close the burst only if the counter sat at 2.
    load_fifo(10, 6);
    run_until(16, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stream2_timeout: got %0d beats expected 16", obs_data_q.size());
    end
    for (int i = 0; i < obs_data_q.size(); i++) begin
      n_checks++;
      if (obs_data_q[i] !== exp_q[i] || obs_last_q[i] !== (i == 7 || i == 15)) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got data=%0h last=%b expected data=%0h last=%b",
                 i, obs_data_q[i], obs_last_q[i], exp_q[i], (i == 7 || i == 15));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    m_ready = 1'b0;
    n_pops  = 0;
    load_fifo(0, 5);
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 32'd0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b data=%0h expected 1 0", i, m_valid, m_data);
      end
    end
    n_checks++;
    if (n_pops != 2 || rinc !== 1'b0 || fifo_q.size() != 3) begin
      n_fail++;
      $display("FAIL bp_pops: got pops=%0d rinc=%b left=%0d expected 2 0 3",
               n_pops, rinc, fifo_q.size());
    end
    m_ready = 1'b1;
    run_until(5, 30, ok);
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (obs_data_q.size() != 5 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats idle=%b expected 5 1", obs_data_q.size(), idle);
    end
    for (int i = 0; i < obs_data_q.size() && i < 5; i++) begin
      n_checks++;
      if (obs_data_q[i] !== 32'(i) || obs_last_q[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got data=%0h last=%b expected data=%0h last=0",
                 i, obs_data_q[i], obs_last_q[i], i);
      end
    end
  endtask

  task automatic test_en_toggle();
    bit ok;
    bit exp_last[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    clear_obs();
    en      = 1'b1;
    m_ready = 1'b0;
    n_pops  = 0;
    load_fifo(20, 5);
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (n_pops != 2) begin
      n_fail++;
      $display("FAIL en_fill: got %0d pops expected 2", n_pops);
    end
    en      = 1'b0;
    m_ready = 1'b1;
    #1;
    n_checks++;
    if (rinc !== 1'b0) begin
      n_fail++;
      $display("FAIL en_off_rinc: got %b expected 0", rinc);
    end
    n_pops = 0;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (n_pops != 0 || obs_data_q.size() != 2 || idle !== 1'b1 || fifo_q.size() != 3) begin
      n_fail++;
      $display("FAIL en_drain: got pops=%0d beats=%0d idle=%b left=%0d expected 0 2 1 3",
               n_pops, obs_data_q.size(), idle, fifo_q.size());
    end
    en = 1'b1;
    #1;
    n_checks++;
    if (rinc !== 1'b1) begin
      n_fail++;
      $display("FAIL en_on_rinc: got %b expected 1", rinc);
    end
    run_until(5, 30, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL en_timeout: got %0d beats expected 5", obs_data_q.size());
    end
    for (int i = 0; i < obs_data_q.size() && i < 5; i++) begin
      n_checks++;
      if (obs_data_q[i] !== 32'(20 + i) || obs_last_q[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL en_beat%0d: got data=%0h last=%b expected data=%0h last=%b",
                 i, obs_data_q[i], obs_last_q[i], 20 + i, exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_obs();
    m_ready = 1'b1;
    load_fifo(30, 3);
    run_until(3, 20, ok);
    n_checks++;
    if (!ok || obs_last_q[0] || obs_last_q[1] || obs_last_q[2]) begin
      n_fail++;
      $display("FAIL rm_pre: got %0d beats with a last expected 3 beats without last",
               obs_data_q.size());
    end
    m_ready = 1'b0;
    load_fifo(33, 3);
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 32'd33 || rinc !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_full: got valid=%b data=%0h rinc=%b expected 1 21 0",
               m_valid, m_data, rinc);
    end
    #2;
    rrst_n = 1'b0;
    fifo_q.delete();
    refresh_fifo();
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || idle !== 1'b1 || m_data !== 32'd0 || rinc !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async: got valid=%b last=%b idle=%b data=%0h rinc=%b expected 0 0 1 0 0",
               m_valid, m_last, idle, m_data, rinc);
    end
    cycle();
    #3;
    rrst_n = 1'b1;
    cycle();
    clear_obs();
    m_ready = 1'b1;
    load_fifo(40, 8);
    run_until(8, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rm_timeout: got %0d beats expected 8", obs_data_q.size());
    end
    for (int i = 0; i < obs_data_q.size() && i < 8; i++) begin
      n_checks++;
      if (obs_data_q[i] !== 32'(40 + i) || obs_last_q[i] !== (i == 7)) begin
        n_fail++;
        $display("FAIL rm_beat%0d: got data=%0h last=%b expected data=%0h last=%b",
                 i, obs_data_q[i], obs_last_q[i], 40 + i, (i == 7));
      end
    end
  endtask

  task automatic test_burst1();
    logic [9:0] ready_pat = 10'b11_1011_0110;
    int n_last1 = 0;
    clear_obs();
    load_fifo(50, 6);
    for (int i = 0; i < 10; i++) begin
      m_ready = ready_pat[i];
      #1;
      n_checks++;
      if (m_last1 !== m_valid1 || m_data1 !== m_data) begin
        n_fail++;
        $display("FAIL b1_cycle%0d: got last=%b data=%0h expected last=%b data=%0h",
                 i, m_last1, m_data1, m_valid1, m_data);
      end
      if (m_valid1 && m_ready) n_last1++;
      cycle();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid1 && m_last1) n_last1++;
      cycle();
    end
    n_checks++;
    if (n_last1 != 6 || idle1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b1_count: got last beats=%0d idle=%b expected 6 1", n_last1, idle1);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_en_toggle();
    test_reset_mid();
    test_burst1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_stream.md
# async_fifo_rd_stream

Read-side adapter that sits directly downstream of `async_fifo` in the read clock domain. It pops words from the FIFO's first-word-fall-through read port (`rempty`/`rinc`/`rdata`), holds them in a 2-entry register buffer, and presents them as a valid/ready stream. Every `BURST` accepted beats it marks a boundary with `m_last`. `rinc` is a function of local state only and never depends combinationally on `m_ready`.

## Interface
Parameters:
- `DSIZE`, 32, data width; must match the FIFO's `DSIZE`.
- `BURST`, 8, beats per burst for `m_last`; legal range 1..256.

Ports:
- `rclk`  in  1  read-domain clock, same clock as the FIFO read side.
- `rrst_n`  in  1  asynchronous active-low reset, shared with the FIFO read side.
- `en`  in  1  pop enable; when low, no new FIFO pops, but buffered words still drain.
- `rempty`  in  1  FIFO empty flag; `rdata` is valid whenever this is low.
- `rinc`  out  1  FIFO pop strobe; the word on `rdata` is consumed at the `rclk` edge where `rinc` is high.
- `rdata`  in  DSIZE  FIFO head word (first-word fall-through).
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DSIZE  output word.
- `m_last`  out  1  high on the final beat of each `BURST`-beat group; qualified by `m_valid`.
- `idle`  out  1  high when the buffer is empty (occupancy 0).

## Operation
- Internal buffer: 2 entries (head, tail) with occupancy `occ` of 0, 1 or 2.
- Pop rule: `rinc = en && !rempty && (occ < 2)`. This is combinational from `occ`, `en` and `rempty` only.
- Accept rule: a beat is accepted when `m_valid && m_ready`. `m_valid = (occ != 0)` and `m_data = head`.
- Occupancy update per edge, with pop = `rinc` and acc = accept:
  - pop and no acc: `occ + 1`.
  - acc and no pop: `occ - 1`.
  - both, or neither: unchanged.
- Data movement:
  - On accept, `tail` shifts into `head`.
  - A popped word is written to the lowest free slot after that shift.
  - Order is strictly preserved.
- Pop with `occ == 2` is not possible.
- Pop and accept at `occ == 1`: the new word goes directly into `head`.
- `m_data` and `m_valid` hold stable while `m_valid && !m_ready`. Words already presented are never dropped.
- Burst counter `bcnt`:
  - Width `max(1, $clog2(BURST))`, counts accepted beats modulo `BURST`.
  - `m_last = m_valid && (bcnt == BURST-1)`.
  - With `BURST == 1`, `m_last = m_valid`.
  - `bcnt` wraps from `BURST-1` to 0 on accept.
  - `bcnt` is unaffected by `en`.
- `arempty` from the FIFO is not used.

## Timing
- Reset (async assert, sync release to `rclk`):
  - `occ = 0`, `bcnt = 0`.
  - Outputs: `m_valid = 0`, `m_last = 0`, `idle = 1`, `m_data = 0`.
  - `rinc` reset value is 0, because `en`/`rempty` gating holds off pops until the FIFO is out of reset; `rinc` follows the pop rule once reset releases.
- Latency: a word popped at edge N appears with `m_valid = 1` in the cycle after edge N. It can be accepted at edge N+1.
- Throughput: 1 word per cycle when `m_ready` is held high and the FIFO is non-empty. Steady-state `occ` is 1.
- Backpressure: if `m_ready` drops, at most 2 words are held. `rinc` deasserts in the cycle `occ` reaches 2.
- Reset mid-operation: buffered words and `bcnt` are discarded immediately. The first beat after reset starts a new burst.
- `en` falling: takes effect on the same cycle's `rinc` (combinational). Words already buffered continue to drain.

## Structure
- Package `async_fifo_pkg`: `BURST` range check function and the `bcnt` width function.
- Natural sub-module: `stream_skid_buf2`, the 2-entry ordered register buffer with push/pop, `occ`, head/tail.
- The top level holds the pop rule, burst counter and `m_last` logic.

## Test plan
- Reset then idle: `rempty = 1`, `en = 1` → `rinc = 0`, `m_valid = 0`, `idle = 1`, `m_last = 0`.
- Stream 10 words 0..9, `m_ready = 1`, `BURST = 8` →
  - output sequence 0..9 in order at 1 per cycle;
  - `m_last` high on word 7 only among 0..9;
  - `bcnt = 2` at the end.
- Backpressure: `m_ready = 0` with 5 words in the FIFO →
  - exactly 2 pops, then `rinc = 0`;
  - `m_data = 0` held stable;
  - after `m_ready = 1`, all 5 words arrive in order with no loss or duplication.
- `en` toggle: `en = 0` with 3 words available →
  - no pops;
  - buffered words drain;
  - `en = 1` resumes pops on the same cycle.
- `BURST = 1` → `m_last == m_valid` on every beat.
- Async reset asserted with `occ = 2` and `bcnt = 5` →
  - outputs return to reset values immediately;
  - after release, the next burst's `m_last` falls on its 8th beat.
